unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle.sv | 126 ++++++++++++
 tb/tb_unidade_controle.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Control unit for a simple multi-cycle processor: a 2-bit step counter
// plus combinational decode of IR into datapath enables.
module unidade_controle (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [8:0] IR,
  input  logic       G_zero,
  output logic       IRin,
  output logic [7:0] Rin,
  output logic [7:0] Rout,
  output logic       Ain,
  output logic       Gin,
  output logic       Gout,
  output logic       DINout,
  output logic       AddSub,
  output logic       Done,
  output logic [1:0] Tstep
);

  localparam int unsigned STEP_W = 2;
  localparam int unsigned REG_N  = 8;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  localparam logic [STEP_W-1:0] T0 = 2'd0;
  localparam logic [STEP_W-1:0] T1 = 2'd1;
  localparam logic [STEP_W-1:0] T2 = 2'd2;
  localparam logic [STEP_W-1:0] T3 = 2'd3;

  logic [STEP_W-1:0] tstep_q;
  logic [STEP_W-1:0] tstep_d;
  logic [2:0]        opcode;
  logic [REG_N-1:0]  rx_onehot;
  logic [REG_N-1:0]  ry_onehot;
  logic              is_alu;
  logic              step_done;

  assign opcode    = IR[8:6];
  assign rx_onehot = REG_N'(8'h01) << IR[5:3];
  assign ry_onehot = REG_N'(8'h01) << IR[2:0];
  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign Tstep     = tstep_q;

  // Final step of the current instruction, independent of Reset gating.
  always_comb begin
    step_done = 1'b0;
    case (tstep_q)
      T0:      step_done = 1'b0;
      T1:      step_done = !is_alu;
      default: step_done = (tstep_q == T3) || !is_alu;
    endcase
  end

  // Step counter register
  always_ff @(posedge Clock) begin
    if (Reset) tstep_q <= T0;
    else       tstep_q <= tstep_d;
  end

  // Next-step logic
  always_comb begin
    tstep_d = T0;
    if (step_done)           tstep_d = T0;
    else if (tstep_q == T0)  tstep_d = Run ? T1 : T0;
    else                     tstep_d = tstep_q + STEP_W'(1);
  end

  // Output decode; Reset forces every control low in the same cycle
  always_comb begin
    IRin   = 1'b0;
    Rin    = '0;
    Rout   = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    DINout = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    if (!Reset) begin
      Done = step_done;
      case (tstep_q)
        T0: IRin = Run;
        T1: begin
          case (opcode)
            OP_MV: begin
              Rout = ry_onehot;
              Rin  = rx_onehot;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin    = rx_onehot;
            end
            OP_ADD, OP_SUB: begin
              Rout = rx_onehot;
              Ain  = 1'b1;
            end
            OP_MVNZ: begin
              Rout = ry_onehot;
              Rin  = G_zero ? '0 : rx_onehot;
            end
            default: ;
          endcase
        end
        T2: begin
          if (is_alu) begin
            Rout   = ry_onehot;
            Gin    = 1'b1;
            AddSub = (opcode == OP_SUB);
          end
        end
        default: begin
          if (is_alu) begin
            Gout = 1'b1;
            Rin  = rx_onehot;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with hand-computed expectations.
module tb_unidade_controle;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Run;
  logic [8:0] IR;
  logic       G_zero;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       Ain, Gin, Gout, DINout, AddSub, Done;
  logic [1:0] Tstep;

  int checks = 0;
  int errors = 0;

  unidade_controle dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .IR     (IR),
    .G_zero (G_zero),
    .IRin   (IRin),
    .Rin    (Rin),
    .Rout   (Rout),
    .Ain    (Ain),
    .Gin    (Gin),
    .Gout   (Gout),
    .DINout (DINout),
    .AddSub (AddSub),
    .Done   (Done),
    .Tstep  (Tstep)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one edge, then leave time for inputs to be changed and settle.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; IR = 9'b0; G_zero = 1'b0;
    step(); step();
    settle();
    chk("rst_tstep", 32'(Tstep), 0);
    chk("rst_irin",  32'(IRin), 0);
    chk("rst_done",  32'(Done), 0);
    chk("rst_rin",   32'(Rin), 0);
    chk("rst_rout",  32'(Rout), 0);

    // mv R0,R1
    Reset = 1'b0; Run = 1'b1; IR = 9'b000_000_001;
    settle();
    chk("mv_t0_irin", 32'(IRin), 1);
    step(); Run = 1'b0; settle();
    chk("mv_t1_tstep", 32'(Tstep), 1);
    chk("mv_t1_rout",  32'(Rout), 32'h02);
    chk("mv_t1_rin",   32'(Rin), 32'h01);
    chk("mv_t1_done",  32'(Done), 1);
    step(); settle();
    chk("mv_after_tstep", 32'(Tstep), 0);

    // mvi R0
    IR = 9'b001_000_001; Run = 1'b1; settle();
    step(); Run = 1'b0; settle();
    chk("mvi_t1_dinout", 32'(DINout), 1);
    chk("mvi_t1_rin",    32'(Rin), 32'h01);
    chk("mvi_t1_rout",   32'(Rout), 32'h00);
    chk("mvi_t1_done",   32'(Done), 1);
    step(); settle();
    chk("mvi_after_tstep", 32'(Tstep), 0);

    // sub R1,R0 (Run dropped after T0 must not abort)
    IR = 9'b011_001_000; Run = 1'b1; settle();
    step(); Run = 1'b0; settle();
    chk("sub_t1_rout", 32'(Rout), 32'h02);
    chk("sub_t1_ain",  32'(Ain), 1);
    chk("sub_t1_done", 32'(Done), 0);
    step(); settle();
    chk("sub_t2_tstep",  32'(Tstep), 2);
    chk("sub_t2_rout",   32'(Rout), 32'h01);
    chk("sub_t2_gin",    32'(Gin), 1);
    chk("sub_t2_addsub", 32'(AddSub), 1);
    chk("sub_t2_rin",    32'(Rin), 0);
    step(); settle();
    chk("sub_t3_tstep", 32'(Tstep), 3);
    chk("sub_t3_gout",  32'(Gout), 1);
    chk("sub_t3_rin",   32'(Rin), 32'h02);
    chk("sub_t3_rout",  32'(Rout), 0);
    chk("sub_t3_done",  32'(Done), 1);
    step(); settle();
    chk("sub_after_tstep", 32'(Tstep), 0);

    // mvnz R0,R1 with G_zero=1: no write
    IR = 9'b100_000_001; G_zero = 1'b1; Run = 1'b1; settle();
    step(); Run = 1'b0; settle();
    chk("mvnz_z_rin",  32'(Rin), 0);
    chk("mvnz_z_done", 32'(Done), 1);
    step(); settle();

    // mvnz with G_zero=0, Run held for back-to-back start
    G_zero = 1'b0; Run = 1'b1; settle();
    step(); settle();
    chk("mvnz_nz_rin",  32'(Rin), 32'h01);
    chk("mvnz_nz_rout", 32'(Rout), 32'h02);
    chk("mvnz_nz_done", 32'(Done), 1);
    step(); settle();
    chk("b2b_tstep", 32'(Tstep), 0);
    chk("b2b_irin",  32'(IRin), 1);

    // Idle with Run low
    Run = 1'b0; settle();
    for (int i = 0; i < 5; i++) begin
      chk("idle_tstep", 32'(Tstep), 0);
      chk("idle_irin",  32'(IRin), 0);
      step(); settle();
    end

    // NOP opcode
    IR = 9'b101_010_011; Run = 1'b1; settle();
    step(); Run = 1'b0; settle();
    chk("nop_tstep", 32'(Tstep), 1);
    chk("nop_done",  32'(Done), 1);
    chk("nop_rin",   32'(Rin), 0);
    chk("nop_rout",  32'(Rout), 0);
    step(); settle();
    chk("nop_after_tstep", 32'(Tstep), 0);

    // add R3,R4 with Reset pulsed at T2
    IR = 9'b010_011_100; Run = 1'b1; settle();
    step(); Run = 1'b0; settle();
    chk("add_t1_rout", 32'(Rout), 32'h08);
    step(); settle();
    chk("add_t2_rout",   32'(Rout), 32'h10);
    chk("add_t2_addsub", 32'(AddSub), 0);
    Reset = 1'b1; settle();
    chk("add_rst_gin",  32'(Gin), 0);
    chk("add_rst_rout", 32'(Rout), 0);
    step(); Reset = 1'b0; settle();
    chk("add_rst_tstep", 32'(Tstep), 0);
    chk("add_rst_gout",  32'(Gout), 0);
    chk("add_rst_rin",   32'(Rin), 0);
    step(); settle();
    chk("add_rst_stay", 32'(Tstep), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
